// File: rtl/demux_1to2_32bit.sv
// demux_1to2_32bit: registered 1:2 demux, one-entry valid/ready slot per output.
// Define DEMUX_BROADCAST_EN to add the broadcast port that writes both slots at once.
module demux_1to2_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             select,
  input  logic [WIDTH-1:0] data_in,
`ifdef DEMUX_BROADCAST_EN
  input  logic             broadcast,
`endif
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state      [2];
  state_t           state_next [2];
  logic [WIDTH-1:0] data_q     [2];
  logic [1:0]       rdy, can_acc, load, valid;
  logic             bcast;
`ifdef DEMUX_BROADCAST_EN
  assign bcast = broadcast;
`else
  assign bcast = 1'b0;
`endif
  assign rdy = {out1_ready, out0_ready};
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      state[i]  <= reset ? EMPTY : state_next[i];
      data_q[i] <= reset ? '0 : load[i] ? data_in : data_q[i];
    end
  end
  // A full slot can refill in the same cycle its consumer drains it.
  always_comb begin
    for (int i = 0; i < 2; i++) can_acc[i] = state[i] == EMPTY || rdy[i];
    in_ready = bcast ? &can_acc : can_acc[select];
    for (int i = 0; i < 2; i++) begin
      load[i]       = in_valid && in_ready && (bcast || select == 1'(i));
      state_next[i] = load[i] ? FULL : (state[i] == FULL && rdy[i]) ? EMPTY : state[i];
    end
  end
  always_comb begin
    for (int i = 0; i < 2; i++) valid[i] = state[i] == FULL;
  end
  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
endmodule

// File: tb/tb_demux_1to2_32bit.sv
// tb_demux_1to2_32bit: scoreboard bench for demux_1to2_32bit.
module tb_demux_1to2_32bit;
  logic        clock = 0;
  logic        reset = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic        select = 0;
  logic [31:0] data_in = '0;
  logic        out0_valid, out1_valid;
  logic        out0_ready = 0;
  logic        out1_ready = 0;
  logic [31:0] out0_data, out1_data;
  logic        broadcast = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        known = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  demux_1to2_32bit dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .data_in(data_in),
`ifdef DEMUX_BROADCAST_EN
    .broadcast(broadcast),
`endif
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    logic c0, c1, b;
    c0 = q0.size() == 0 || out0_ready;
    c1 = q1.size() == 0 || out1_ready;
`ifdef DEMUX_BROADCAST_EN
    b = broadcast;
`else
    b = 1'b0;
`endif
    return b ? (c0 && c1) : (select ? c1 : c0);
  endfunction

  // Inputs are already driven; check at negedge, then advance the model on the edge.
  task automatic cycle();
    logic acc, b, d0, d1;
    @(negedge clock);
    if (known) begin
      check("in_ready", 32'(in_ready), 32'(model_ready()));
      check("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
      check("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
      if (q0.size() != 0) check("out0_data", out0_data, q0[0]);
      if (q1.size() != 0) check("out1_data", out1_data, q1[0]);
    end
    @(posedge clock);
`ifdef DEMUX_BROADCAST_EN
    b = broadcast;
`else
    b = 1'b0;
`endif
    if (reset) begin
      q0.delete();
      q1.delete();
      known = 1;
    end else begin
      acc = in_valid && model_ready();
      d0 = q0.size() != 0 && out0_ready;
      d1 = q1.size() != 0 && out1_ready;
      if (d0) void'(q0.pop_front());
      if (d1) void'(q1.pop_front());
      if (acc && (b || !select)) q0.push_back(data_in);
      if (acc && (b || select)) q1.push_back(data_in);
    end
    #1;
  endtask

  initial begin
    reset = 1;
    repeat (2) cycle();
    reset = 0;
    check("rst_out0_data", out0_data, 32'h0);
    check("rst_out1_data", out1_data, 32'h0);
    cycle();
    // unicast into stalled slot 0
    select = 0; data_in = 32'h12345678; in_valid = 1;
    cycle();
    in_valid = 0;
    check("uni_out0_data", out0_data, 32'h12345678);
    cycle();
    // slot 1 still accepts while slot 0 stalls
    select = 1; data_in = 32'h87654321; in_valid = 1;
    cycle();
    in_valid = 0;
    check("stall_out1_data", out1_data, 32'h87654321);
    check("stall_out0_data", out0_data, 32'h12345678);
    cycle();
    out1_ready = 1;
    cycle();
    // back-to-back streaming on slot 1
    for (int i = 0; i < 8; i++) begin
      select = 1; data_in = 32'(i); in_valid = 1;
      cycle();
      check("stream_out1_data", out1_data, 32'(i));
    end
    in_valid = 0;
    repeat (2) cycle();
    out1_ready = 0;
    // drain slot 0, then simultaneous drain and refill
    out0_ready = 1;
    cycle();
    out0_ready = 0; select = 0; data_in = 32'hABCDEF01; in_valid = 1;
    cycle();
    out0_ready = 1; data_in = 32'h543210FF;
    cycle();
    in_valid = 0; out0_ready = 0;
    check("refill_out0_valid", 32'(out0_valid), 32'h1);
    check("refill_out0_data", out0_data, 32'h543210FF);
    cycle();
    // random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      select = 1'($urandom_range(0, 1));
      data_in = $urandom;
      out0_ready = 1'($urandom_range(0, 2) != 0);
      out1_ready = 1'($urandom_range(0, 3) == 0);
`ifdef DEMUX_BROADCAST_EN
      broadcast = 1'($urandom_range(0, 4) == 0);
`endif
      cycle();
    end
    broadcast = 0;
    // fill both slots, then reset mid-operation with a live handshake
    in_valid = 1; out0_ready = 0; out1_ready = 0;
    select = 0; data_in = 32'h11111111; out0_ready = 1;
    cycle();
    out0_ready = 0; select = 1; data_in = 32'h22222222; out1_ready = 1;
    cycle();
    out1_ready = 0; in_valid = 0;
    cycle();
    reset = 1; in_valid = 1; select = 0; data_in = 32'hFFFFFFFF; out0_ready = 1;
    cycle();
    reset = 0; in_valid = 0; out0_ready = 0;
    check("midrst_out0_valid", 32'(out0_valid), 32'h0);
    check("midrst_out1_valid", 32'(out1_valid), 32'h0);
    check("midrst_out0_data", out0_data, 32'h0);
    check("midrst_out1_data", out1_data, 32'h0);
    cycle();
`ifdef DEMUX_BROADCAST_EN
    select = 1; data_in = 32'h33333333; in_valid = 1;
    cycle();
    broadcast = 1; data_in = 32'hDEADBEEF;
    @(negedge clock);
    check("bcast_blocked", 32'(in_ready), 32'h0);
    cycle();
    out1_ready = 1;
    cycle();
    broadcast = 0; in_valid = 0; out1_ready = 0;
    check("bcast_out0_data", out0_data, 32'hDEADBEEF);
    check("bcast_out1_data", out1_data, 32'hDEADBEEF);
    cycle();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_1to2_32bit.md
# demux_1to2_32bit

Registered 1-to-2 demultiplexer that steers a 32-bit word from one producer to one of two consumers. It is the distribution-side counterpart of the 2:1 source-select mux in the datapath, for example routing an execution result to either the register-file write port or the data-memory write port. Each output has a one-entry holding register with a valid/ready handshake, so a stalled consumer never corrupts or drops data.

## Interface
- WIDTH, 32, data width of input and both outputs
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer presents a word
- in_ready  output  1  block accepts the word this cycle
- select  input  1  destination: 0 → output 0, 1 → output 1
- data_in  input  WIDTH  input word
- out0_valid  output  1  slot 0 holds a word
- out0_ready  input  1  consumer 0 takes the word
- out0_data  output  WIDTH  slot 0 word
- out1_valid  output  1  slot 1 holds a word
- out1_ready  input  1  consumer 1 takes the word
- out1_data  output  WIDTH  slot 1 word
- broadcast  input  1  present only with DEMUX_BROADCAST_EN; write both slots

## Operation
- Each output slot is a two-state FSM: EMPTY or FULL. outN_valid = (state == FULL). outN_data is the slot register.
- Input transfer: in_valid && in_ready at the rising edge.
- Output transfer: outN_valid && outN_ready at the rising edge.
- Slot N can accept this cycle when it is EMPTY, or when it is FULL and outN_ready = 1 (pass-through refill).
- in_ready = accept capability of the slot addressed by select. It is combinational from select, the slot state and outN_ready. It does not depend on in_valid.
- On an input transfer, data_in is loaded into the selected slot and the slot becomes FULL. The unselected slot is untouched.
- Slot transitions:
  - EMPTY → FULL on input transfer.
  - FULL → EMPTY on output transfer without a simultaneous input transfer.
  - FULL → FULL (new data) on a simultaneous output and input transfer.
- outN_data holds its value while FULL and not drained. After draining, the value is don't-care; the implementation keeps the last value.
- Ordering is preserved per output. No ordering guarantee exists between the two outputs.
- Words are never dropped or duplicated. Every accepted word appears exactly once on exactly one output, or on both in broadcast mode.
- select and data_in are sampled only on an input transfer; their value when in_valid = 0 is ignored.

## Timing
- Reset: both slots EMPTY; out0_valid = out1_valid = 0; out0_data = out1_data = 0. in_ready reads 1 in the first cycle after reset, because the selected slot is EMPTY.
- Latency: a word accepted at edge k is visible on outN_data with outN_valid = 1 from edge k to edge k+1.
- Throughput: one word per cycle per output when the consumer holds outN_ready = 1 continuously.
- A stall on one output does not block words destined for the other output.
- Reset asserted mid-operation: held words are discarded and both slots return to EMPTY at that edge. Handshakes during the reset cycle have no effect.
- Consumers may assert outN_ready while outN_valid = 0; this is harmless.

## Configuration
- DEMUX_BROADCAST_EN defined:
  - The broadcast port exists.
  - When broadcast = 1, in_ready = (slot 0 can accept) AND (slot 1 can accept), and select is ignored.
  - On the transfer, data_in is loaded into both slots.
- DEMUX_BROADCAST_EN undefined:
  - The broadcast port and its logic are absent.
  - Behaviour is exactly the unicast operation above.

## Test plan
- Reset then unicast: reset 1 for 2 cycles, then select=0, data_in=32'h12345678, in_valid=1, out0_ready=0 → next cycle out0_valid=1, out0_data=32'h12345678, out1_valid=0, in_ready(select=0)=0.
- Independent stall: slot 0 FULL with out0_ready=0; send select=1, data_in=32'h87654321 → accepted; out1_data=32'h87654321 one cycle later; slot 0 unchanged.
- Back-to-back streaming: out1_ready=1; send 8 words 32'h0..32'h7 to select=1 on consecutive cycles → in_ready stays 1; out1_data shows 0..7 in order, one per cycle.
- Simultaneous drain and refill: slot 0 holds 32'hABCDEF01, out0_ready=1, new word 32'h543210FF to select=0 → out0_data=32'h543210FF next cycle; out0_valid stays 1; no cycle is lost.
- Reset mid-operation: both slots FULL, then reset=1 for one cycle → out0_valid=out1_valid=0 and out0_data=out1_data=0 after that edge.
- Broadcast (DEMUX_BROADCAST_EN defined): broadcast=1, data_in=32'hDEADBEEF, slot 1 FULL with out1_ready=0 → in_ready=0. Then set out1_ready=1 → transfer occurs; both outputs show 32'hDEADBEEF the next cycle.
